// File: rtl/fifo_stream_reader.sv
// -----------------------------------------------------------------------------
// fifo_stream_reader
//
// Read-side companion to a synchronous FIFO with a registered read port
// (data appears the cycle after fifo_rd_en). Pops words from the FIFO and
// presents them as a valid/ready stream. A small skid buffer holds the words
// that are already committed by the FIFO's one-cycle read latency, so the
// stream runs at one word per cycle while the FIFO has data and the consumer
// keeps m_ready high.
//
// Ports
//   clk           single clock, all logic on posedge
//   rst           asynchronous reset, active-high
//   fifo_empty    FIFO empty flag
//   fifo_rd_en    pop request to the FIFO (combinational)
//   fifo_rd_data  FIFO read data, valid the cycle after fifo_rd_en
//   flush         discard buffered and in-flight words
//   m_valid       stream word available
//   m_ready       consumer accepts the word
//   m_data        stream word (head of the skid buffer)
//   words_out     count of completed m_valid && m_ready transfers (wraps)
//
// Stream handshake: a word transfers on every rising edge where m_valid and
// m_ready are both high. Once m_valid is raised it stays high, with m_data
// unchanged, until that transfer happens; only flush or rst may withdraw it.
// m_valid never depends combinationally on m_ready.
// -----------------------------------------------------------------------------
module fifo_stream_reader #(
  parameter int DATA_WIDTH  = 32,
  parameter int SKID_DEPTH  = 2,
  parameter int COUNT_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   fifo_empty,
  output logic                   fifo_rd_en,
  input  logic [DATA_WIDTH-1:0]  fifo_rd_data,
  input  logic                   flush,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic [DATA_WIDTH-1:0]  m_data,
  output logic [COUNT_WIDTH-1:0] words_out
);

  localparam int PTR_W = (SKID_DEPTH > 1) ? $clog2(SKID_DEPTH) : 1;
  localparam int OCC_W = $clog2(SKID_DEPTH + 1);

  localparam logic [OCC_W:0]   DEPTH_C  = (OCC_W + 1)'(SKID_DEPTH);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(SKID_DEPTH - 1);

  // Skid buffer storage and bookkeeping.
  logic [DATA_WIDTH-1:0]  buf_q [SKID_DEPTH];
  logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
  logic [OCC_W-1:0]       occ_q, occ_d;
  logic                   inflight_q;
  logic [COUNT_WIDTH-1:0] words_q;

  logic                   pop;
  logic                   capture;
  logic [OCC_W:0]         committed;

  // Circular pointer advance; the depth need not be a power of two.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
  endfunction

  assign m_valid   = (occ_q != '0);
  assign m_data    = buf_q[rd_ptr_q];
  assign words_out = words_q;

  assign pop     = m_valid && m_ready;
  // A word returning from the FIFO while flush is high is dropped.
  assign capture = inflight_q && !flush;

  // Slots already spoken for after this edge: buffered words plus the word
  // still in the FIFO's read pipeline, less the one leaving now. A new read
  // is only issued when that leaves a free slot, so capture never overflows.
  assign committed = {1'b0, occ_q}
                   + {{OCC_W{1'b0}}, inflight_q}
                   - {{OCC_W{1'b0}}, pop};

  assign fifo_rd_en = !rst && !flush && !fifo_empty && (committed < DEPTH_C);

  always_comb begin
    occ_d    = occ_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    if (flush) begin
      occ_d    = '0;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
    end else begin
      if (capture && !pop) begin
        occ_d = occ_q + OCC_W'(1);
      end else if (!capture && pop) begin
        occ_d = occ_q - OCC_W'(1);
      end
      if (pop) begin
        rd_ptr_d = ptr_inc(rd_ptr_q);
      end
      if (capture) begin
        wr_ptr_d = ptr_inc(wr_ptr_q);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      occ_q      <= '0;
      inflight_q <= 1'b0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      words_q    <= '0;
      for (int i = 0; i < SKID_DEPTH; i++) begin
        buf_q[i] <= '0;
      end
    end else begin
      occ_q      <= occ_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      // fifo_rd_en is already low during flush, so this also clears it.
      inflight_q <= fifo_rd_en;
      if (capture) begin
        buf_q[wr_ptr_q] <= fifo_rd_data;
      end
      // A transfer that coincides with flush still counts.
      if (pop) begin
        words_q <= words_q + COUNT_WIDTH'(1);
      end
    end
  end

endmodule

// File: tb/tb_fifo_stream_reader.sv
// -----------------------------------------------------------------------------
// tb_fifo_stream_reader
//
// Drives fifo_stream_reader from a behavioural sync FIFO (array plus push/pop
// counts, registered read data) and checks the stream against the words in
// FIFO order. A flush or reset drops everything already popped from the FIFO,
// so the expected stream restarts at the current FIFO head.
// Skid depth 3 exercises non-power-of-two wrap; a 4-bit counter shows wrap.
// -----------------------------------------------------------------------------
module tb_fifo_stream_reader;

  localparam int DW    = 32;
  localparam int SD    = 3;
  localparam int CW    = 4;
  localparam int MEM_N = 4096;

  logic          clk = 1'b0;
  logic          rst;
  logic          fifo_empty;
  logic          fifo_rd_en;
  logic [DW-1:0] fifo_rd_data = '0;
  logic          flush;
  logic          m_valid;
  logic          m_ready;
  logic [DW-1:0] m_data;
  logic [CW-1:0] words_out;

  int            vec_cnt = 0;
  int            err_cnt = 0;
  logic [DW-1:0] exp_q[$];
  logic [CW-1:0] exp_wo;

  // Behavioural FIFO: words fifo_mem[pop_cnt .. push_cnt-1] are queued.
  logic [DW-1:0] fifo_mem [MEM_N];
  int            push_cnt = 0;
  int            pop_cnt  = 0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  fifo_stream_reader #(
    .DATA_WIDTH (DW),
    .SKID_DEPTH (SD),
    .COUNT_WIDTH(CW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .fifo_empty  (fifo_empty),
    .fifo_rd_en  (fifo_rd_en),
    .fifo_rd_data(fifo_rd_data),
    .flush       (flush),
    .m_valid     (m_valid),
    .m_ready     (m_ready),
    .m_data      (m_data),
    .words_out   (words_out)
  );

  assign fifo_empty = (push_cnt == pop_cnt);

  always @(posedge clk) begin
    if (fifo_rd_en && (pop_cnt < push_cnt)) begin
      fifo_rd_data <= fifo_mem[pop_cnt % MEM_N];
      pop_cnt      <= pop_cnt + 1;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic push_word(input logic [DW-1:0] w);
    fifo_mem[push_cnt % MEM_N] = w;
    push_cnt = push_cnt + 1;
    exp_q.push_back(w);
  endtask

  // Words popped from the FIFO but not yet delivered are lost.
  task automatic drop_to_fifo_head();
    exp_q.delete();
    for (int i = pop_cnt; i < push_cnt; i++) exp_q.push_back(fifo_mem[i % MEM_N]);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; m_ready = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    vec_cnt++; if (m_valid !== 1'b0) begin err_cnt++; $display("FAIL reset_m_valid: got %b want 0", m_valid); end
    vec_cnt++; if (m_data !== '0) begin err_cnt++; $display("FAIL reset_m_data: got %h want 0", m_data); end
    vec_cnt++; if (words_out !== '0) begin err_cnt++; $display("FAIL reset_words_out: got %0d want 0", words_out); end
    vec_cnt++; if (fifo_rd_en !== 1'b0) begin err_cnt++; $display("FAIL reset_rd_en: got %b want 0", fifo_rd_en); end
    @(negedge clk);
    rst = 1'b0; exp_wo = '0;
    #1;
    vec_cnt++; if (m_valid !== 1'b0 || fifo_rd_en !== 1'b0) begin
      err_cnt++; $display("FAIL idle_after_reset: m_valid=%b rd_en=%b want 0/0", m_valid, fifo_rd_en);
    end
  endtask

  task automatic test_stream_basic();
    int first_rd = -1, first_v = -1, last_v = -1, got = 0;
    @(negedge clk);
    m_ready = 1'b1;
    for (int i = 0; i < 8; i++) push_word(DW'(32'hA0 + i));
    for (int c = 0; c < 20; c++) begin
      if (c != 0) @(negedge clk);
      #1;
      if (fifo_rd_en && first_rd < 0) first_rd = c;
      vec_cnt++; if (words_out !== exp_wo) begin err_cnt++; $display("FAIL basic_count c=%0d: got %0d want %0d", c, words_out, exp_wo); end
      if (m_valid && m_ready) begin
        if (first_v < 0) first_v = c;
        last_v = c; got++;
        vec_cnt++;
        if (exp_q.size() == 0 || m_data !== exp_q[0]) begin err_cnt++; $display("FAIL basic_data c=%0d: got %h want %h", c, m_data, (exp_q.size() != 0) ? exp_q[0] : 'x); end
        if (exp_q.size() != 0) void'(exp_q.pop_front());
        exp_wo++;
      end
    end
    vec_cnt++; if (got != 8) begin err_cnt++; $display("FAIL basic_words: got %0d want 8", got); end
    vec_cnt++; if (first_v - first_rd != 2) begin err_cnt++; $display("FAIL basic_latency: got %0d want 2", first_v - first_rd); end
    vec_cnt++; if (last_v - first_v != 7) begin err_cnt++; $display("FAIL basic_gapless: span %0d want 7", last_v - first_v); end
    vec_cnt++; if (words_out !== CW'(8)) begin err_cnt++; $display("FAIL basic_words_out: got %0d want 8", words_out); end
  endtask

  task automatic test_backpressure();
    int pulses = 0, got = 0, first_v = -1, last_v = -1;
    logic [DW-1:0] head;
    @(negedge clk);
    m_ready = 1'b0;
    for (int i = 0; i < 4; i++) push_word(DW'(32'hB0 + i));
    head = exp_q[0];
    for (int c = 0; c < 10; c++) begin
      if (c != 0) @(negedge clk);
      #1;
      if (fifo_rd_en) pulses++;
      if (c >= 2) begin
        vec_cnt++;
        if (m_valid !== 1'b1 || m_data !== head) begin err_cnt++; $display("FAIL bp_hold c=%0d: valid=%b data=%h want 1/%h", c, m_valid, m_data, head); end
      end
    end
    vec_cnt++; if (pulses != SD) begin err_cnt++; $display("FAIL bp_rd_pulses: got %0d want %0d", pulses, SD); end
    @(negedge clk);
    m_ready = 1'b1;
    for (int c = 0; c < 20 && got < 4; c++) begin
      if (c != 0) @(negedge clk);
      #1;
      if (m_valid && m_ready) begin
        if (first_v < 0) first_v = c;
        last_v = c; got++;
        vec_cnt++;
        if (exp_q.size() == 0 || m_data !== exp_q[0]) begin err_cnt++; $display("FAIL bp_drain c=%0d: got %h want %h", c, m_data, (exp_q.size() != 0) ? exp_q[0] : 'x); end
        if (exp_q.size() != 0) void'(exp_q.pop_front());
        exp_wo++;
      end
    end
    vec_cnt++; if (got != 4 || last_v - first_v != 3) begin err_cnt++; $display("FAIL bp_drain_gapless: got %0d words span %0d want 4/3", got, last_v - first_v); end
  endtask

  task automatic test_flush();
    int got = 0, got2 = 0;
    // Fill until occ=2 with one word in flight, then flush.
    @(negedge clk);
    m_ready = 1'b0;
    for (int i = 0; i < 6; i++) push_word(DW'(32'hC0 + i));
    repeat (3) @(negedge clk);
    flush = 1'b1;
    #1;
    vec_cnt++; if (m_valid !== 1'b1 || m_data !== DW'(32'hC0)) begin err_cnt++; $display("FAIL flush_pre: valid=%b data=%h want 1/c0", m_valid, m_data); end
    vec_cnt++; if (fifo_rd_en !== 1'b0) begin err_cnt++; $display("FAIL flush_rd_en: got %b want 0", fifo_rd_en); end
    drop_to_fifo_head();
    @(negedge clk);
    flush = 1'b0;
    #1;
    vec_cnt++; if (m_valid !== 1'b0) begin err_cnt++; $display("FAIL flush_clear: m_valid=%b want 0", m_valid); end
    vec_cnt++; if (words_out !== exp_wo) begin err_cnt++; $display("FAIL flush_count: got %0d want %0d", words_out, exp_wo); end
    m_ready = 1'b1;
    for (int c = 0; c < 20 && got < 3; c++) begin
      @(negedge clk); #1;
      if (m_valid && m_ready) begin
        got++; vec_cnt++;
        if (exp_q.size() == 0 || m_data !== exp_q[0]) begin err_cnt++; $display("FAIL flush_resume: got %h want %h", m_data, (exp_q.size() != 0) ? exp_q[0] : 'x); end
        if (exp_q.size() != 0) void'(exp_q.pop_front());
        exp_wo++;
      end
    end
    vec_cnt++; if (got != 3) begin err_cnt++; $display("FAIL flush_resume_words: got %0d want 3", got); end
    // A transfer in the flush cycle completes and is counted.
    @(negedge clk);
    m_ready = 1'b1;
    for (int i = 0; i < 4; i++) push_word(DW'(32'hD0 + i));
    repeat (2) @(negedge clk);
    flush = 1'b1;
    #1;
    vec_cnt++;
    if (m_valid !== 1'b1 || m_data !== DW'(32'hD0)) begin err_cnt++; $display("FAIL flush_pop_data: valid=%b data=%h want 1/d0", m_valid, m_data); end
    exp_wo++;
    drop_to_fifo_head();
    @(negedge clk);
    flush = 1'b0;
    #1;
    vec_cnt++; if (m_valid !== 1'b0) begin err_cnt++; $display("FAIL flush_pop_clear: m_valid=%b want 0", m_valid); end
    vec_cnt++; if (words_out !== exp_wo) begin err_cnt++; $display("FAIL flush_pop_count: got %0d want %0d", words_out, exp_wo); end
    for (int c = 0; c < 20 && got2 < 2; c++) begin
      @(negedge clk); #1;
      if (m_valid && m_ready) begin
        got2++; vec_cnt++;
        if (exp_q.size() == 0 || m_data !== exp_q[0]) begin err_cnt++; $display("FAIL flush_pop_resume: got %h want %h", m_data, (exp_q.size() != 0) ? exp_q[0] : 'x); end
        if (exp_q.size() != 0) void'(exp_q.pop_front());
        exp_wo++;
      end
    end
    vec_cnt++; if (got2 != 2) begin err_cnt++; $display("FAIL flush_pop_resume_words: got %0d want 2", got2); end
  endtask

  task automatic test_count_wrap();
    int got = 0;
    bit saw15 = 1'b0, wrapped = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; exp_wo = '0;
    drop_to_fifo_head();
    m_ready = 1'b1;
    for (int i = 0; i < 17; i++) push_word($urandom());
    for (int c = 0; c < 40; c++) begin
      if (c != 0) @(negedge clk);
      #1;
      vec_cnt++; if (words_out !== exp_wo) begin err_cnt++; $display("FAIL wrap_count c=%0d: got %0d want %0d", c, words_out, exp_wo); end
      if (words_out == CW'(15)) saw15 = 1'b1;
      if (saw15 && words_out == '0) wrapped = 1'b1;
      if (m_valid && m_ready) begin
        got++; vec_cnt++;
        if (exp_q.size() == 0 || m_data !== exp_q[0]) begin err_cnt++; $display("FAIL wrap_data: got %h want %h", m_data, (exp_q.size() != 0) ? exp_q[0] : 'x); end
        if (exp_q.size() != 0) void'(exp_q.pop_front());
        exp_wo++;
      end
    end
    vec_cnt++; if (got != 17 || !saw15 || !wrapped) begin err_cnt++; $display("FAIL wrap_seq: words=%0d saw15=%b wrapped=%b want 17/1/1", got, saw15, wrapped); end
    vec_cnt++; if (words_out !== CW'(1)) begin err_cnt++; $display("FAIL wrap_final: got %0d want 1", words_out); end
  endtask

  task automatic test_reset_midstream();
    int got = 0;
    @(negedge clk);
    m_ready = 1'b1;
    for (int i = 0; i < 6; i++) push_word(DW'(32'hE0 + i));
    repeat (2) @(negedge clk);
    #1;
    vec_cnt++; if (m_valid !== 1'b1 || m_data !== DW'(32'hE0)) begin err_cnt++; $display("FAIL midrst_pre: valid=%b data=%h want 1/e0", m_valid, m_data); end
    rst = 1'b1;
    #1;
    vec_cnt++; if (m_valid !== 1'b0) begin err_cnt++; $display("FAIL midrst_m_valid: got %b want 0", m_valid); end
    vec_cnt++; if (fifo_rd_en !== 1'b0) begin err_cnt++; $display("FAIL midrst_rd_en: got %b want 0", fifo_rd_en); end
    vec_cnt++; if (m_data !== '0) begin err_cnt++; $display("FAIL midrst_m_data: got %h want 0", m_data); end
    vec_cnt++; if (words_out !== '0) begin err_cnt++; $display("FAIL midrst_words_out: got %0d want 0", words_out); end
    exp_wo = '0;
    drop_to_fifo_head();
    @(negedge clk); #1;
    vec_cnt++; if (fifo_rd_en !== 1'b0) begin err_cnt++; $display("FAIL midrst_rd_en_held: got %b want 0", fifo_rd_en); end
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 20 && got < 4; c++) begin
      if (c != 0) @(negedge clk);
      #1;
      vec_cnt++; if (words_out !== exp_wo) begin err_cnt++; $display("FAIL midrst_count: got %0d want %0d", words_out, exp_wo); end
      if (m_valid && m_ready) begin
        got++; vec_cnt++;
        if (exp_q.size() == 0 || m_data !== exp_q[0]) begin err_cnt++; $display("FAIL midrst_resume: got %h want %h", m_data, (exp_q.size() != 0) ? exp_q[0] : 'x); end
        if (exp_q.size() != 0) void'(exp_q.pop_front());
        exp_wo++;
      end
    end
    vec_cnt++; if (got != 4) begin err_cnt++; $display("FAIL midrst_resume_words: got %0d want 4", got); end
  endtask

  task automatic test_random();
    int pushed = 0, got = 0;
    logic prev_stall = 1'b0;
    logic [DW-1:0] prev_data = '0;
    for (int c = 0; c < 10000 && got < 1000; c++) begin
      @(negedge clk);
      if (pushed < 1000 && $urandom_range(0, 1) == 1) begin
        push_word($urandom());
        pushed++;
      end
      m_ready = 1'($urandom_range(0, 1));
      #1;
      vec_cnt++; if (fifo_rd_en && fifo_empty) begin err_cnt++; $display("FAIL rand_rd_empty c=%0d: rd_en=1 while fifo_empty=1", c); end
      if (prev_stall) begin
        vec_cnt++;
        if (m_valid !== 1'b1 || m_data !== prev_data) begin err_cnt++; $display("FAIL rand_stall_hold c=%0d: valid=%b data=%h want 1/%h", c, m_valid, m_data, prev_data); end
      end
      vec_cnt++; if (words_out !== exp_wo) begin err_cnt++; $display("FAIL rand_count c=%0d: got %0d want %0d", c, words_out, exp_wo); end
      if (m_valid && m_ready) begin
        got++; vec_cnt++;
        if (exp_q.size() == 0 || m_data !== exp_q[0]) begin err_cnt++; $display("FAIL rand_data c=%0d: got %h want %h", c, m_data, (exp_q.size() != 0) ? exp_q[0] : 'x); end
        if (exp_q.size() != 0) void'(exp_q.pop_front());
        exp_wo++;
      end
      prev_stall = m_valid && !m_ready;
      prev_data  = m_data;
    end
    vec_cnt++; if (got != 1000 || exp_q.size() != 0) begin err_cnt++; $display("FAIL rand_total: got %0d words, %0d left, want 1000/0", got, exp_q.size()); end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    rst = 1'b1; flush = 1'b0; m_ready = 1'b0; exp_wo = '0;
    test_reset();
    test_stream_basic();
    test_backpressure();
    test_flush();
    test_count_wrap();
    test_reset_midstream();
    test_random();
    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

  initial begin
    #2000000;
    err_cnt++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
